// File: rtl/usb_pkg.sv
// Shared USB transmit-path definitions: encoder packet-type codes, payload
// widths and the arbiter state encoding.
package usb_pkg;

  localparam logic [1:0] PKT_NONE   = 2'b00;
  localparam logic [1:0] PKT_DATA   = 2'b01;
  localparam logic [1:0] PKT_TOKEN  = 2'b10;
  localparam logic [1:0] PKT_HSHAKE = 2'b11;

  localparam int DATA_W   = 88;
  localparam int TOKEN_W  = 24;
  localparam int HSHAKE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY,
    ST_GAP
  } arb_state_t;

endpackage

// File: rtl/tx_timer.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module tx_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/usb_tx_arbiter.sv
// Fixed-priority arbiter feeding the single USB bit-stream encoder, with a
// data starvation guard, inter-packet gap and encoder watchdog.
module usb_tx_arbiter
  import usb_pkg::*;
#(
  parameter int IPG      = 4,
  parameter int TIMEOUT  = 1024,
  parameter int MAX_SKIP = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hs_req,
  input  logic [HSHAKE_W-1:0] hs_pkt,
  input  logic                tok_req,
  input  logic [TOKEN_W-1:0]  tok_pkt,
  input  logic                dat_req,
  input  logic [DATA_W-1:0]   dat_pkt,
  output logic                hs_gnt,
  output logic                tok_gnt,
  output logic                dat_gnt,
  output logic                done,
  output logic [1:0]          done_type,
  output logic                err,
  input  logic                enc_free,
  output logic [1:0]          enc_pkt_type,
  output logic [DATA_W-1:0]   enc_data,
  output logic [TOKEN_W-1:0]  enc_token,
  output logic [HSHAKE_W-1:0] enc_hshake
);

  localparam int TMAX = (IPG > TIMEOUT) ? IPG : TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int SW   = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
  localparam logic [TW-1:0] BUSY_LOAD = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD  = (IPG > 0) ? TW'(IPG - 1) : '0;
  localparam logic [SW-1:0] SKIP_MAX  = SW'(MAX_SKIP);

  arb_state_t          r_state, w_next;
  logic [1:0]          r_type, w_sel;
  logic [DATA_W-1:0]   r_data;
  logic [TOKEN_W-1:0]  r_token;
  logic [HSHAKE_W-1:0] r_hshake;
  logic [SW-1:0]       r_skip;
  logic                r_done, r_err;
  logic [1:0]          r_done_type;
  logic                w_load, w_dec, w_zero, w_complete, w_abort;
  logic [TW-1:0]       w_load_val;

  tx_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .i_dec   (w_dec),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // The timer serves BUSY as a watchdog and GAP as the spacing counter.
  always_comb begin
    w_next     = r_state;
    w_sel      = PKT_NONE;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    w_complete = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enc_free) begin
          if (dat_req && (r_skip == SKIP_MAX)) w_sel = PKT_DATA;
          else if (hs_req)                     w_sel = PKT_HSHAKE;
          else if (tok_req)                    w_sel = PKT_TOKEN;
          else if (dat_req)                    w_sel = PKT_DATA;
          if (w_sel != PKT_NONE) w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_load     = 1'b1;
        w_load_val = BUSY_LOAD;
        w_next     = ST_BUSY;
      end
      ST_BUSY: begin
        if (enc_free)    w_complete = 1'b1;
        else if (w_zero) w_abort    = 1'b1;
        else             w_dec      = 1'b1;
        if (w_complete || w_abort) begin
          if (IPG == 0) begin
            w_next = ST_IDLE;
          end else begin
            w_next     = ST_GAP;
            w_load     = 1'b1;
            w_load_val = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (w_zero) w_next = ST_IDLE;
        else        w_dec  = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_type      <= PKT_NONE;
      r_data      <= '0;
      r_token     <= '0;
      r_hshake    <= '0;
      r_done      <= 1'b0;
      r_done_type <= PKT_NONE;
      r_err       <= 1'b0;
    end else begin
      if (w_sel != PKT_NONE) begin
        r_type <= w_sel;
        case (w_sel)
          PKT_DATA:  r_data   <= dat_pkt;
          PKT_TOKEN: r_token  <= tok_pkt;
          default:   r_hshake <= hs_pkt;
        endcase
      end
      r_done      <= w_complete;
      r_done_type <= w_complete ? r_type : PKT_NONE;
      r_err       <= w_abort;
    end
  end

  // Counts control grants that jumped ahead of a waiting data packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skip <= '0;
    end else if (!dat_req) begin
      r_skip <= '0;
    end else if (r_state == ST_ISSUE) begin
      if (r_type == PKT_DATA)    r_skip <= '0;
      else if (r_skip != SKIP_MAX) r_skip <= r_skip + 1'b1;
    end
  end

  assign enc_pkt_type = (r_state == ST_ISSUE) ? r_type : PKT_NONE;
  assign hs_gnt       = (r_state == ST_ISSUE) && (r_type == PKT_HSHAKE);
  assign tok_gnt      = (r_state == ST_ISSUE) && (r_type == PKT_TOKEN);
  assign dat_gnt      = (r_state == ST_ISSUE) && (r_type == PKT_DATA);
  assign done         = r_done;
  assign done_type    = r_done_type;
  assign err          = r_err;
  assign enc_data     = r_data;
  assign enc_token    = r_token;
  assign enc_hshake   = r_hshake;

endmodule
